iq_issue_reader: RTL
====================

Name: iq_issue_reader

Overview:
- Consumer side of the dual-slot instruction queue between ID and IR.
- Each cycle, inspects the two head entries and selects 0, 1 or 2 instructions in program order.
- Blocks on register hazards using a 32-entry busy scoreboard plus a check between the two slots.
- Pops the issued entries and registers them into the IR-stage pipeline register, honouring downstream stall and flush.

Parameters:
- NUM_SCALAR_INSTR, 2, issue slots; only 2 is supported.
- NUM_REGS, 32, architectural integer registers tracked by the scoreboard.
- DUAL_ISSUE_EN, 1, when 0 slot 1 never issues.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush
- stall_i  in  1  downstream cannot accept; hold output register
- iq_instr_S_i  in  id_ir_stage_t[2]  queue head entries; slot 0 is the oldest
- iq_empty_i  in  1  queue empty
- read_head_S_o  out  1[2]  pop requests to the queue (combinational)
- wb_valid_i  in  1[2]  writeback ports valid
- wb_rd_i  in  5[2]  writeback destination registers
- issue_S_o  out  id_ir_stage_t[2]  registered issued instructions
- issue_valid_o  out  1[2]  registered slot valids

Behaviour:
- Fields used from each entry: instr.valid, instr.rs1, instr.rs2, instr.rd, instr.regfile_we.
  - rs1/rs2 are always treated as read; a false hazard costs only performance.
- Slot valid:
  - v0 = ~iq_empty_i & iq_instr_S_i[0].instr.valid.
  - v1 = ~iq_empty_i & iq_instr_S_i[1].instr.valid.
- Effective busy for register r:
  - busy[r] & ~(clear from either wb port for r this cycle).
  - A writeback in the same cycle as the check therefore unblocks issue.
  - x0 is never busy.
- issue0 = v0 & ~stall_i & ~flush_i & no effective-busy hit on rs1, rs2, or on rd when regfile_we is set (WAW).
- issue1 = DUAL_ISSUE_EN & issue0 & v1 & no effective-busy hit on its own operands. Additionally, issue1 is blocked when:
  - slot1 rs1 or rs2 equals slot0 rd, with slot0 regfile_we set and rd != 0; or
  - both slots write the same nonzero rd.
- read_head_S_o[i] = issue_i. Same cycle as the check; the queue advances at the next edge.
  - read_head_S_o[1] is never asserted without read_head_S_o[0].
- Output register, posedge:
  - Stall: when stall_i, issue_S_o and issue_valid_o hold their values.
  - Otherwise, issue_S_o[i] <= iq_instr_S_i[i] and issue_valid_o[i] <= issue_i.
  - Latency from pop to output is 1 cycle.
- Scoreboard update, posedge, when not flushing:
  - Clear the bit for each valid wb port with rd != 0.
  - Set the bit for each issued slot with regfile_we set and rd != 0.
  - If set and clear hit the same register, set wins.
- Flush:
  - read_head_S_o = 0 in the flush cycle.
  - Next edge: issue_valid_o = 0, issue_S_o = 0, scoreboard cleared, writebacks in that cycle ignored.
  - Flush has priority over stall.
- Reset, asynchronous: issue_valid_o = 0, issue_S_o = 0, scoreboard = 0.
  - read_head_S_o is 0 while rstn_i is low, because issue logic is gated by reset.
  - Reset asserted mid-operation discards any registered instructions.
- Queue empty: no pops, and issue_valid_o becomes 0 on the next unstalled edge.
- Only slot0 valid: single issue; slot1 is never popped alone.

Test Plan:
- Reset then empty queue for 3 cycles -> read_head_S_o = 00 and issue_valid_o = 00 throughout.
- Pair add x5,x1,x2 / add x6,x3,x4, scoreboard clear -> read_head_S_o = 11; next cycle issue_valid_o = 11 and busy[5] = busy[6] = 1.
- Pair add x5,x1,x2 / sub x7,x5,x1 -> read_head_S_o = 01. Next cycle the sub is at slot0 and busy[5] = 1, so no issue; wb_valid_i[0] = 1 with wb_rd_i[0] = 5 in that cycle -> sub issues in the same cycle.
- stall_i held high for 2 cycles with a valid pair -> read_head_S_o = 00 and issue_S_o unchanged; stall released -> pair popped and issued 1 cycle later.
- busy[9] set and flush_i pulsed with a valid pair -> no pops; next cycle scoreboard = 0 and issue_valid_o = 00.
- Pair writing x0 / reading x0, with DUAL_ISSUE_EN = 1 -> both issue and the scoreboard stays 0; repeat with DUAL_ISSUE_EN = 0 -> only slot0 pops per cycle.

Source files
------------

// File: rtl/iq_issue_reader.sv
// Issue stage reader for the dual-slot ID->IR instruction queue: picks 0/1/2 head
// entries in order, blocks on scoreboard and intra-pair hazards, registers the result.
module iq_issue_reader #(
    parameter int NUM_SCALAR_INSTR = 2,
    parameter int NUM_REGS         = 32,
    parameter int DUAL_ISSUE_EN    = 1,
    parameter int ENTRY_W          = 49
) (
    input  logic                                      clk_i,
    input  logic                                      rstn_i,
    input  logic                                      flush_i,
    input  logic                                      stall_i,
    input  logic [NUM_SCALAR_INSTR-1:0][ENTRY_W-1:0]  iq_instr_S_i,
    input  logic                                      iq_empty_i,
    output logic [NUM_SCALAR_INSTR-1:0]               read_head_S_o,
    input  logic [NUM_SCALAR_INSTR-1:0]               wb_valid_i,
    input  logic [NUM_SCALAR_INSTR-1:0][4:0]          wb_rd_i,
    output logic [NUM_SCALAR_INSTR-1:0][ENTRY_W-1:0]  issue_S_o,
    output logic [NUM_SCALAR_INSTR-1:0]               issue_valid_o,
    output logic [NUM_REGS-1:0]                       busy_o
);

    // Entry layout: {payload, regfile_we, rd, rs2, rs1, valid}
    localparam int VLD_BIT = 0;
    localparam int RS1_LO  = 1;
    localparam int RS2_LO  = 6;
    localparam int RD_LO   = 11;
    localparam int WE_BIT  = 16;
    localparam logic DUAL_EN = (DUAL_ISSUE_EN != 0);

    logic [NUM_SCALAR_INSTR-1:0][ENTRY_W-1:0] issue_S_q;
    logic [NUM_SCALAR_INSTR-1:0]              issue_valid_q;
    logic [NUM_REGS-1:0]                      busy_q;
    logic [NUM_REGS-1:0]                      busy_d;

    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] eff_busy;
    logic [4:0]          rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    logic                v0, v1, we_0, we_1;
    logic                raw_pair, waw_pair;
    logic                issue0, issue1;

    always_comb begin
        rs1_0 = iq_instr_S_i[0][RS1_LO +: 5];
        rs2_0 = iq_instr_S_i[0][RS2_LO +: 5];
        rd_0  = iq_instr_S_i[0][RD_LO +: 5];
        we_0  = iq_instr_S_i[0][WE_BIT];
        rs1_1 = iq_instr_S_i[1][RS1_LO +: 5];
        rs2_1 = iq_instr_S_i[1][RS2_LO +: 5];
        rd_1  = iq_instr_S_i[1][RD_LO +: 5];
        we_1  = iq_instr_S_i[1][WE_BIT];
        v0    = ~iq_empty_i & iq_instr_S_i[0][VLD_BIT];
        v1    = ~iq_empty_i & iq_instr_S_i[1][VLD_BIT];

        // A same-cycle writeback releases the register for this cycle's check
        wb_clr = '0;
        for (int p = 0; p < 2; p++) begin
            if (wb_valid_i[p] && (wb_rd_i[p] != 5'd0)) begin
                wb_clr[wb_rd_i[p]] = 1'b1;
            end
        end
        eff_busy    = busy_q & ~wb_clr;
        eff_busy[0] = 1'b0;

        raw_pair = we_0 && (rd_0 != 5'd0) && ((rs1_1 == rd_0) || (rs2_1 == rd_0));
        waw_pair = we_0 && we_1 && (rd_0 != 5'd0) && (rd_1 == rd_0);

        issue0 = rstn_i & v0 & ~stall_i & ~flush_i
               & ~eff_busy[rs1_0] & ~eff_busy[rs2_0] & ~(we_0 & eff_busy[rd_0]);
        issue1 = DUAL_EN & issue0 & v1
               & ~eff_busy[rs1_1] & ~eff_busy[rs2_1] & ~(we_1 & eff_busy[rd_1])
               & ~raw_pair & ~waw_pair;

        set_mask = '0;
        if (issue0 && we_0 && (rd_0 != 5'd0)) set_mask[rd_0] = 1'b1;
        if (issue1 && we_1 && (rd_1 != 5'd0)) set_mask[rd_1] = 1'b1;

        // Set is ORed in after the clear so a new writer wins over a retiring one
        busy_d    = (busy_q & ~wb_clr) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            issue_S_q     <= '0;
            issue_valid_q <= '0;
            busy_q        <= '0;
        end else if (flush_i) begin
            issue_S_q     <= '0;
            issue_valid_q <= '0;
            busy_q        <= '0;
        end else begin
            if (!stall_i) begin
                issue_S_q     <= iq_instr_S_i;
                issue_valid_q <= {issue1, issue0};
            end
            busy_q <= busy_d;
        end
    end

    assign read_head_S_o = {issue1, issue0};
    assign issue_S_o     = issue_S_q;
    assign issue_valid_o = issue_valid_q;
    assign busy_o        = busy_q;

endmodule
